// File: rtl/lfsr_bus_interface_n.sv
// Bank of NUM_CH independent Galois LFSRs behind one bus port with base-address decode.
// One read is served per rd assertion; the bus can also reseed any channel.
module lfsr_bus_interface_n #(
    parameter int                NUM_CH    = 16,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 4,
    parameter int                BASE_ADDR = 0,
    parameter logic [DATA_W-1:0] TAPS      = 32'h80200003,
    parameter logic [DATA_W-1:0] SEED      = 32'hACE1ACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] d,
    output logic              d_valid,
    output logic              ack,
    output logic              err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W:0] BASE_EXT = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] NUM_EXT  = (ADDR_W+1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] lfsr [NUM_CH];
    logic [CH_W-1:0]   ch_q;
    logic [ADDR_W:0]   offset;
    logic              hit;
    logic [CH_W-1:0]   ch;

    // An address below the base wraps to a value above 2^ADDR_W, so one compare covers both bounds.
    assign offset = {1'b0, a} - BASE_EXT;
    assign hit    = (offset < NUM_EXT);
    assign ch     = CH_W'(offset);

    function automatic logic [DATA_W-1:0] reset_seed(input int idx);
        logic [DATA_W-1:0] v;
        v = SEED ^ DATA_W'(idx);
        return (v == '0) ? DATA_W'(1) : v;
    endfunction

    function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ch_q    <= '0;
            d       <= '0;
            d_valid <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                lfsr[i] <= reset_seed(i);
            end
        end else begin
            d       <= '0;
            d_valid <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd) begin
                        // A simultaneous write is dropped and flagged; the read still goes ahead.
                        err <= wr || !hit;
                        if (hit) begin
                            ch_q  <= ch;
                            state <= RD;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (wr) begin
                        if (hit) begin
                            lfsr[ch] <= (wdata == '0) ? reset_seed(int'(ch)) : wdata;
                            ack      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RD: begin
                    d          <= lfsr[ch_q];
                    d_valid    <= 1'b1;
                    lfsr[ch_q] <= step(lfsr[ch_q]);
                    state      <= HOLD;
                end
                HOLD: begin
                    if (!rd) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_bus_interface_n.sv
// Bench for lfsr_bus_interface_n: a default instance (unit 0) and a BASE_ADDR=4, NUM_CH=8 instance (unit 1).
// Expected read data is queued when a read is issued and compared when d_valid appears.
module tb_lfsr_bus_interface_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a0, a1;
    logic        rd0, rd1, wr0, wr1;
    logic [31:0] wd0, wd1;
    logic [31:0] d0, d1;
    logic        dv0, dv1, ack0, ack1, err0, err1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          dv_cnt[2];
    int          ack_cnt[2];
    int          err_cnt[2];

    always #5 clk = ~clk;

    lfsr_bus_interface_n dut0 (
        .clk(clk), .rst(rst), .a(a0), .rd(rd0), .wr(wr0), .wdata(wd0),
        .d(d0), .d_valid(dv0), .ack(ack0), .err(err0)
    );

    lfsr_bus_interface_n #(.NUM_CH(8), .BASE_ADDR(4)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .rd(rd1), .wr(wr1), .wdata(wd1),
        .d(d1), .d_valid(dv1), .ack(ack1), .err(err1)
    );

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int u, input logic [31:0] exp);
        if (u == 0) q0.push_back(exp);
        else        q1.push_back(exp);
    endtask

    task automatic flush_queues();
        q0.delete();
        q1.delete();
    endtask

    task automatic drive(input int u, input logic [3:0] addr, input logic r, input logic w,
                         input logic [31:0] wd);
        if (u == 0) begin a0 = addr; rd0 = r; wr0 = w; wd0 = wd; end
        else        begin a1 = addr; rd1 = r; wr1 = w; wd1 = wd; end
    endtask

    task automatic monitor(input int u, input logic dv, input logic [31:0] dd,
                           input logic ak, input logic er);
        logic [31:0] exp;
        if (ak === 1'b1) ack_cnt[u]++;
        if (er === 1'b1) err_cnt[u]++;
        vectors++;
        if (dv === 1'b1) begin
            dv_cnt[u]++;
            if (qsize(u) == 0) begin
                miscompares++;
                $display("FAIL unexpected_dvalid unit %0d: d_valid=1 d=%h, required no read output", u, dd);
            end else begin
                exp = (u == 0) ? q0.pop_front() : q1.pop_front();
                if (dd !== exp) begin
                    miscompares++;
                    $display("FAIL rd_data unit %0d: d=%h, required %h", u, dd, exp);
                end
            end
        end else if (dd !== 32'h0) begin
            miscompares++;
            $display("FAIL d_idle unit %0d: d=%h while d_valid=%b, required 0", u, dd, dv);
        end
    endtask

    always @(negedge clk) begin
        monitor(0, dv0, d0, ack0, err0);
        monitor(1, dv1, d1, ack1, err1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 4'd0, 1'b0, 1'b0, 32'h0);
        drive(1, 4'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        flush_queues();
    endtask

    task automatic do_read(input int u, input logic [3:0] addr, input logic [31:0] exp,
                           input string name);
        int n;
        @(negedge clk);
        drive(u, addr, 1'b1, 1'b0, 32'h0);
        push(u, exp);
        @(negedge clk);
        drive(u, addr, 1'b0, 1'b0, 32'h0);
        n = 0;
        while (qsize(u) != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (qsize(u) != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no d_valid within 10 cycles, required d=%h", name, exp);
            flush_queues();
        end
        @(negedge clk);
    endtask

    task automatic do_access(input int u, input logic [3:0] addr, input logic r, input logic w,
                             input logic [31:0] wd, input int exp_ack, input int exp_err,
                             input int exp_dv, input string name);
        int ack_s, err_s, dv_s;
        ack_s = ack_cnt[u]; err_s = err_cnt[u]; dv_s = dv_cnt[u];
        @(negedge clk);
        drive(u, addr, r, w, wd);
        @(negedge clk);
        drive(u, addr, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        vectors++;
        if (ack_cnt[u] - ack_s !== exp_ack) begin
            miscompares++;
            $display("FAIL %s ack: %0d pulses, required %0d", name, ack_cnt[u] - ack_s, exp_ack);
        end
        vectors++;
        if (err_cnt[u] - err_s !== exp_err) begin
            miscompares++;
            $display("FAIL %s err: %0d pulses, required %0d", name, err_cnt[u] - err_s, exp_err);
        end
        vectors++;
        if (dv_cnt[u] - dv_s !== exp_dv) begin
            miscompares++;
            $display("FAIL %s d_valid: %0d pulses, required %0d", name, dv_cnt[u] - dv_s, exp_dv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 4'd0, 1'b0, 1'b0, 32'h0);
        drive(1, 4'd0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({d0, dv0, ack0, err0} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_unit0: d=%h dv=%b ack=%b err=%b, required all 0", d0, dv0, ack0, err0);
        end
        vectors++;
        if ({d1, dv1, ack1, err1} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_unit1: d=%h dv=%b ack=%b err=%b, required all 0", d1, dv1, ack1, err1);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_read();
        do_read(0, 4'd0, 32'hACE1ACE1, "basic_first");
        do_read(0, 4'd0, 32'hD650D673, "basic_step");
    endtask

    task automatic test_isolation();
        do_reset();
        do_read(0, 4'd1, 32'hACE1ACE0, "iso_ch1_first");
        do_read(0, 4'd1, 32'h5670D670, "iso_ch1_step");
        do_read(0, 4'd0, 32'hACE1ACE1, "iso_ch0_untouched");
        do_read(0, 4'd15, 32'hACE1ACEE, "iso_ch15_top");
    endtask

    task automatic test_write();
        do_reset();
        do_access(0, 4'd3, 1'b0, 1'b1, 32'h00000001, 1, 0, 0, "wr_hit");
        do_read(0, 4'd3, 32'h00000001, "wr_read_seed");
        do_read(0, 4'd3, 32'h80200003, "wr_read_step");
        do_access(0, 4'd3, 1'b0, 1'b1, 32'h00000000, 1, 0, 0, "wr_zero");
        do_read(0, 4'd3, 32'hACE1ACE2, "wr_zero_reseed");
        do_read(0, 4'd2, 32'hACE1ACE3, "wr_neighbour");
    endtask

    task automatic test_base_decode();
        do_access(1, 4'd2, 1'b1, 1'b0, 32'h0, 0, 1, 0, "rd_miss_below");
        do_access(1, 4'd12, 1'b1, 1'b0, 32'h0, 0, 1, 0, "rd_miss_above");
        do_read(1, 4'd11, 32'hACE1ACE6, "base_last_ch");
        do_read(1, 4'd4, 32'hACE1ACE1, "base_first_ch");
        do_access(1, 4'd3, 1'b0, 1'b1, 32'h00000007, 0, 1, 0, "wr_miss");
    endtask

    task automatic test_hold_long();
        int dv_s, ack_s, err_s;
        do_reset();
        dv_s = dv_cnt[0]; ack_s = ack_cnt[0]; err_s = err_cnt[0];
        @(negedge clk);
        drive(0, 4'd0, 1'b1, 1'b0, 32'h0);
        push(0, 32'hACE1ACE1);
        repeat (3) @(negedge clk);
        drive(0, 4'd1, 1'b1, 1'b1, 32'h00000005);
        repeat (3) @(negedge clk);
        drive(0, 4'd0, 1'b1, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        drive(0, 4'd0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        vectors++;
        if (dv_cnt[0] - dv_s !== 1) begin
            miscompares++;
            $display("FAIL hold_one_read: %0d d_valid pulses, required 1", dv_cnt[0] - dv_s);
        end
        vectors++;
        if ((ack_cnt[0] - ack_s) + (err_cnt[0] - err_s) !== 0) begin
            miscompares++;
            $display("FAIL hold_wr_ignored: ack=%0d err=%0d pulses, required 0",
                     ack_cnt[0] - ack_s, err_cnt[0] - err_s);
        end
        do_read(0, 4'd1, 32'hACE1ACE0, "hold_ch1_unchanged");
    endtask

    task automatic test_rd_wr_collision();
        do_reset();
        push(0, 32'hACE1ACE1);
        do_access(0, 4'd0, 1'b1, 1'b1, 32'h12345678, 0, 1, 1, "rd_wr_collide");
        do_read(0, 4'd0, 32'hD650D673, "collide_seed_kept");
    endtask

    task automatic test_back_to_back();
        int dv_s, n;
        do_reset();
        dv_s = dv_cnt[0];
        push(0, 32'hACE1ACE7);
        push(0, 32'hD650D670);
        push(0, 32'h6B286B38);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 4'd6, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            drive(0, 4'd6, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        n = 0;
        while (q0.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (dv_cnt[0] - dv_s !== 3 || q0.size() != 0) begin
            miscompares++;
            $display("FAIL back_to_back: %0d reads served, required 3", dv_cnt[0] - dv_s);
            flush_queues();
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int dv_s;
        do_reset();
        dv_s = dv_cnt[0];
        @(negedge clk);
        drive(0, 4'd0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 4'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++;
        if ({d0, dv0, ack0, err0} !== 35'h0 || dv_cnt[0] != dv_s) begin
            miscompares++;
            $display("FAIL reset_mid_read: d=%h dv=%b ack=%b err=%b pulses=%0d, required all 0",
                     d0, dv0, ack0, err0, dv_cnt[0] - dv_s);
        end
        rst = 1'b1;
        do_read(0, 4'd0, 32'hACE1ACE1, "after_mid_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dv_cnt  = '{0, 0};
        ack_cnt = '{0, 0};
        err_cnt = '{0, 0};
        test_reset();
        test_basic_read();
        test_isolation();
        test_write();
        test_base_decode();
        test_hold_long();
        test_rd_wr_collision();
        test_back_to_back();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
